// File: rtl/lab1_pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer: state encoding,
// default parameter values and timer sizing helper.
package lab1_pll_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_t;

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 100000;
  localparam int unsigned DEF_MAX_RETRIES         = 3;
  localparam int unsigned DEF_LOSS_CNT_W          = 8;

  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/lab1_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, async active-low reset to 0.
module lab1_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lab1_pll_reset_sequencer.sv
// PLL reset sequencer: pulse PLL reset, wait for and qualify lock, release system reset,
// retry on timeout. Optional lock-loss counter enabled by LAB1_PLL_LOSS_CNT_EN.
module lab1_pll_reset_sequencer
  import lab1_pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned LOSS_CNT_W          = DEF_LOSS_CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               soft_reset_req,
  output logic               pll_rst,
  output logic               sys_reset_n,
  output logic               pll_ready,
  output logic               pll_fail,
  output logic [STATE_W-1:0] seq_state
`ifdef LAB1_PLL_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

  localparam int unsigned TIMER_W =
    timer_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  if (RST_PULSE_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
      LOSS_CNT_W < 1) begin : g_param_check
    $error("lab1_pll_reset_sequencer: cycle counts and LOSS_CNT_W must be >= 1");
  end

  seq_state_t         state, state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [RETRY_W-1:0] retries;
  logic               lock_s;
  logic               timeout;
  logic               lock_drop;

  lab1_sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    lock_drop = 1'b0;
    case (state)
      ST_RESET_PLL: if (timer == RST_LAST) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = ST_STABLE;
        end else if (timer == TIMEOUT_LAST) begin
          timeout = 1'b1;
          if (retries < RETRY_MAX) state_nxt = ST_RESET_PLL;
          else                     state_nxt = ST_FAIL;
        end
      end
      ST_STABLE: begin
        if (!lock_s)                  state_nxt = ST_WAIT_LOCK;
        else if (timer >= STABLE_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_RESET_PLL;
          lock_drop = 1'b1;
        end
      end
      ST_FAIL: state_nxt = ST_FAIL;
      default: state_nxt = ST_RESET_PLL;
    endcase
    if (soft_reset_req) begin
      state_nxt = ST_RESET_PLL;
      timeout   = 1'b0;
      lock_drop = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RESET_PLL;
      timer       <= '0;
      retries     <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      pll_ready   <= 1'b0;
      pll_fail    <= 1'b0;
    end else begin
      state <= state_nxt;
      // STABLE is entered on the first good lock sample, so its count starts at one
      if (soft_reset_req || state_nxt != state) begin
        timer <= (state_nxt == ST_STABLE) ? TIMER_ONE : '0;
      end else if (state inside {ST_RESET_PLL, ST_WAIT_LOCK, ST_STABLE}) begin
        timer <= timer + 1'b1;
      end
      if (soft_reset_req || state_nxt == ST_RUN) begin
        retries <= '0;
      end else if (timeout && state_nxt == ST_RESET_PLL) begin
        retries <= retries + 1'b1;
      end
      pll_rst     <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAIL);
      pll_ready   <= (state_nxt == ST_RUN);
      pll_fail    <= (state_nxt == ST_FAIL);
      // one cycle behind the state so release always trails RUN entry by a cycle
      sys_reset_n <= (state == ST_RUN);
    end
  end

  assign seq_state = state;

`ifdef LAB1_PLL_LOSS_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_cnt <= '0;
    end else if (lock_drop && lock_loss_cnt != '1) begin
      lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lab1_pll_reset_sequencer.sv
// Directed self-checking bench for lab1_pll_reset_sequencer with short sim parameters
// (pulse 4, stable 8, timeout 32, retries 2).
module tb_lab1_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       pll_ready;
  logic       pll_fail;
  logic [2:0] seq_state;
`ifdef LAB1_PLL_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  lab1_pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2),
    .LOSS_CNT_W          (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_reset_n    (sys_reset_n),
    .pll_ready      (pll_ready),
    .pll_fail       (pll_fail),
    .seq_state      (seq_state)
`ifdef LAB1_PLL_LOSS_CNT_EN
    ,
    .lock_loss_cnt  (lock_loss_cnt)
`endif
  );

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b0; soft_reset_req = 1'b0;
    tick(3);
    tests++; if (seq_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", seq_state); end
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    tests++; if (sys_reset_n !== 1'b0) begin fails++; $display("FAIL reset_sys_reset_n: got %b want 0", sys_reset_n); end
    tests++; if (pll_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", pll_ready); end
    tests++; if (pll_fail !== 1'b0) begin fails++; $display("FAIL reset_pll_fail: got %b want 0", pll_fail); end
`ifdef LAB1_PLL_LOSS_CNT_EN
    tests++; if (lock_loss_cnt !== 8'd0) begin fails++; $display("FAIL reset_loss_cnt: got %0d want 0", lock_loss_cnt); end
`endif
  endtask

  task automatic test_lock_sequence();
    reset_n = 1'b1;
    tick(3);
    tests++; if (pll_rst !== 1'b1 || seq_state !== 3'd0) begin fails++; $display("FAIL seq_pulse_hold: pll_rst=%b state=%0d want 1/0", pll_rst, seq_state); end
    tick(1);
    tests++; if (pll_rst !== 1'b0 || seq_state !== 3'd1) begin fails++; $display("FAIL seq_pulse_end: pll_rst=%b state=%0d want 0/1", pll_rst, seq_state); end
    tick(10);
    pll_locked = 1'b1;
    tick(3);
    tests++; if (seq_state !== 3'd2) begin fails++; $display("FAIL seq_enter_stable: state=%0d want 2", seq_state); end
    tick(6);
    tests++; if (seq_state !== 3'd2 || pll_ready !== 1'b0) begin fails++; $display("FAIL seq_still_stable: state=%0d ready=%b want 2/0", seq_state, pll_ready); end
    tick(1);
    tests++; if (seq_state !== 3'd3 || pll_ready !== 1'b1 || sys_reset_n !== 1'b0) begin fails++; $display("FAIL seq_run_entry: state=%0d ready=%b sys=%b want 3/1/0", seq_state, pll_ready, sys_reset_n); end
    tick(1);
    tests++; if (sys_reset_n !== 1'b1 || pll_rst !== 1'b0) begin fails++; $display("FAIL seq_sys_release: sys=%b pll_rst=%b want 1/0", sys_reset_n, pll_rst); end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    tick(2);
    tests++; if (seq_state !== 3'd3 || sys_reset_n !== 1'b1) begin fails++; $display("FAIL loss_sync_delay: state=%0d sys=%b want 3/1", seq_state, sys_reset_n); end
    tick(1);
    tests++; if (seq_state !== 3'd0 || pll_ready !== 1'b0 || pll_rst !== 1'b1 || sys_reset_n !== 1'b1) begin
      fails++; $display("FAIL loss_to_reset: state=%0d ready=%b pll_rst=%b sys=%b want 0/0/1/1", seq_state, pll_ready, pll_rst, sys_reset_n);
    end
    tick(1);
    tests++; if (sys_reset_n !== 1'b0) begin fails++; $display("FAIL loss_sys_assert: sys=%b want 0", sys_reset_n); end
`ifdef LAB1_PLL_LOSS_CNT_EN
    tests++; if (lock_loss_cnt !== 8'd1) begin fails++; $display("FAIL loss_cnt_inc: got %0d want 1", lock_loss_cnt); end
`endif
  endtask

  task automatic test_glitch();
    reset_n = 1'b0; pll_locked = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    tests++; if (seq_state !== 3'd1) begin fails++; $display("FAIL glitch_wait: state=%0d want 1", seq_state); end
    pll_locked = 1'b1;
    tick(3);
    tests++; if (seq_state !== 3'd2) begin fails++; $display("FAIL glitch_stable: state=%0d want 2", seq_state); end
    tick(4);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    tests++; if (seq_state !== 3'd2) begin fails++; $display("FAIL glitch_pre_drop: state=%0d want 2", seq_state); end
    tick(1);
    tests++; if (seq_state !== 3'd1) begin fails++; $display("FAIL glitch_back_wait: state=%0d want 1", seq_state); end
    tick(1);
    tests++; if (seq_state !== 3'd2) begin fails++; $display("FAIL glitch_restable: state=%0d want 2", seq_state); end
    tick(6);
    tests++; if (seq_state !== 3'd2) begin fails++; $display("FAIL glitch_requalify: state=%0d want 2", seq_state); end
    tick(1);
    tests++; if (seq_state !== 3'd3 || pll_ready !== 1'b1) begin fails++; $display("FAIL glitch_run: state=%0d ready=%b want 3/1", seq_state, pll_ready); end
  endtask

  task automatic test_never_lock();
    logic exp_rst;
    reset_n = 1'b0; pll_locked = 1'b0;
    tick(2);
    reset_n = 1'b1;
    for (int i = 1; i <= 108; i++) begin
      tick(1);
      exp_rst = (i < 4) || (i >= 36 && i < 40) || (i >= 72 && i < 76) || (i >= 108);
      tests++; if (pll_rst !== exp_rst) begin fails++; $display("FAIL never_lock_pulse: cycle %0d pll_rst=%b want %b", i, pll_rst, exp_rst); end
    end
    tests++; if (seq_state !== 3'd4 || pll_fail !== 1'b1) begin fails++; $display("FAIL never_lock_fail: state=%0d pll_fail=%b want 4/1", seq_state, pll_fail); end
    tests++; if (sys_reset_n !== 1'b0 || pll_ready !== 1'b0) begin fails++; $display("FAIL never_lock_outs: sys=%b ready=%b want 0/0", sys_reset_n, pll_ready); end
    tick(5);
    tests++; if (seq_state !== 3'd4 || pll_rst !== 1'b1) begin fails++; $display("FAIL fail_hold: state=%0d pll_rst=%b want 4/1", seq_state, pll_rst); end
  endtask

  task automatic test_soft_from_fail();
    soft_reset_req = 1'b1; pll_locked = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    tests++; if (seq_state !== 3'd0 || pll_fail !== 1'b0 || pll_rst !== 1'b1) begin
      fails++; $display("FAIL soft_exit_fail: state=%0d pll_fail=%b pll_rst=%b want 0/0/1", seq_state, pll_fail, pll_rst);
    end
    tick(4);
    tests++; if (seq_state !== 3'd1) begin fails++; $display("FAIL soft_wait: state=%0d want 1", seq_state); end
    tick(1);
    tests++; if (seq_state !== 3'd2) begin fails++; $display("FAIL soft_stable: state=%0d want 2", seq_state); end
    tick(7);
    tests++; if (seq_state !== 3'd3 || pll_ready !== 1'b1) begin fails++; $display("FAIL soft_run: state=%0d ready=%b want 3/1", seq_state, pll_ready); end
    tick(1);
    tests++; if (sys_reset_n !== 1'b1) begin fails++; $display("FAIL soft_sys_release: sys=%b want 1", sys_reset_n); end
  endtask

  task automatic test_soft_wins();
    pll_locked = 1'b0;
    tick(2);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    tests++; if (seq_state !== 3'd0 || pll_ready !== 1'b0) begin fails++; $display("FAIL soft_wins_state: state=%0d ready=%b want 0/0", seq_state, pll_ready); end
`ifdef LAB1_PLL_LOSS_CNT_EN
    tests++; if (lock_loss_cnt !== 8'd0) begin fails++; $display("FAIL soft_wins_cnt: got %0d want 0", lock_loss_cnt); end
`endif
  endtask

  task automatic test_async_reset_mid_stable();
    pll_locked = 1'b1;
    tick(7);
    tests++; if (seq_state !== 3'd2) begin fails++; $display("FAIL mid_stable_reach: state=%0d want 2", seq_state); end
    reset_n = 1'b0;
    #2;
    tests++; if (seq_state !== 3'd0 || pll_rst !== 1'b1 || sys_reset_n !== 1'b0 || pll_ready !== 1'b0 || pll_fail !== 1'b0) begin
      fails++; $display("FAIL async_reset: state=%0d pll_rst=%b sys=%b ready=%b pll_fail=%b want 0/1/0/0/0",
                        seq_state, pll_rst, sys_reset_n, pll_ready, pll_fail);
    end
    tick(1);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_lock_loss();
    test_glitch();
    test_never_lock();
    test_soft_from_fail();
    test_soft_wins();
    test_async_reset_mid_stable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
